// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared constants, state encoding and next-address helper for imem_ctrl
package imem_pkg;

    localparam int DEF_ADDR_W   = 12;
    localparam int DEF_DATA_W   = 16;
    localparam int DEF_DEPTH    = 16;
    localparam int DEF_PC_START = 0;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    // Sequential successor of a fetch address; callers truncate to their address width
    function automatic logic [31:0] next_addr(input logic [31:0] addr);
        return addr + 32'd1;
    endfunction

endpackage

// File: rtl/instmem.sv
// rtl/instmem.sv - 16x16 instruction memory with registered read and synchronous write
module instmem
    import imem_pkg::*;
(
    input  logic                  clk,
    input  logic                  we_IM,
    input  logic [DEF_DATA_W-1:0] dataIM,
    input  logic [DEF_ADDR_W-1:0] addIM,
    output logic [DEF_DATA_W-1:0] outIM
);

    localparam logic [DEF_ADDR_W-1:0] DEPTH_A = DEF_ADDR_W'(DEF_DEPTH);

    logic [DEF_DATA_W-1:0] mem [0:DEF_DEPTH-1];
    logic                  in_range;

    assign in_range = (addIM < DEPTH_A);

    // Write port and registered read port; out-of-range addresses read as zero
    always_ff @(posedge clk) begin
        if (we_IM && in_range) begin
            mem[addIM[3:0]] <= dataIM;
        end
        outIM <= in_range ? mem[addIM[3:0]] : '0;
    end

endmodule

// File: rtl/imem_ctrl.sv
// rtl/imem_ctrl.sv - load/run sequencer driving the instruction memory and presenting fetched words
module imem_ctrl
    import imem_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int PC_START = DEF_PC_START
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    input  logic              load_done,
    input  logic              reload,
    input  logic              fetch_en,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              we_IM,
    output logic [DATA_W-1:0] dataIM,
    output logic [ADDR_W-1:0] addIM,
    input  logic [DATA_W-1:0] outIM,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] instr_pc,
    output logic [ADDR_W:0]   load_count,
    output logic              err_oob
);

    localparam logic [ADDR_W:0]   DEPTH_L    = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   PTR_ONE    = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PC_START_L = ADDR_W'(PC_START);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W:0]   load_ptr;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] fetch_addr;
    logic              accept;
    logic              issue;
    logic              oob;

    // The memory's registered read data is the fetched instruction
    assign instr = outIM;

    // Next-state decode and combinational memory-port drive from registered state
    always_comb begin
        state_next = state;
        we_IM      = 1'b0;
        dataIM     = '0;
        addIM      = pc;
        load_ready = 1'b0;
        accept     = 1'b0;
        fetch_addr = pc;
        issue      = 1'b0;
        oob        = 1'b0;
        case (state)
            LOAD: begin
                load_ready = !rst && (load_ptr < DEPTH_L);
                accept     = load_valid && load_ready;
                we_IM      = accept;
                addIM      = load_ptr[ADDR_W-1:0];
                dataIM     = load_data;
                if (load_done || (load_ptr >= DEPTH_L)) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                // Branch beats stall; a stalled valid instruction is re-read so outIM stays put
                if (branch_taken) begin
                    fetch_addr = branch_target;
                end else if (stall && instr_valid) begin
                    fetch_addr = instr_pc;
                end
                addIM = fetch_addr;
                issue = fetch_en && (branch_taken || !stall);
                oob   = issue && ({1'b0, fetch_addr} >= DEPTH_L);
                if (reload) begin
                    state_next = LOAD;
                end else if (oob) begin
                    state_next = HALT;
                end
            end
            HALT: begin
                if (reload) begin
                    state_next = LOAD;
                end
            end
            default: state_next = LOAD;
        endcase
    end

    // State, load pointer, program counter and fetch-status registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= LOAD;
            load_ptr    <= '0;
            load_count  <= '0;
            pc          <= PC_START_L;
            instr_pc    <= PC_START_L;
            instr_valid <= 1'b0;
            err_oob     <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                LOAD: begin
                    if (accept) begin
                        load_ptr   <= load_ptr + PTR_ONE;
                        load_count <= load_count + PTR_ONE;
                    end
                    if (state_next == RUN) begin
                        pc          <= PC_START_L;
                        instr_valid <= 1'b0;
                    end
                end
                RUN: begin
                    if (reload) begin
                        load_ptr    <= '0;
                        load_count  <= '0;
                        err_oob     <= 1'b0;
                        instr_valid <= 1'b0;
                    end else if (oob) begin
                        err_oob     <= 1'b1;
                        instr_valid <= 1'b0;
                    end else if (issue) begin
                        instr_pc    <= fetch_addr;
                        pc          <= ADDR_W'(next_addr(32'(fetch_addr)));
                        instr_valid <= 1'b1;
                    end else if (!fetch_en) begin
                        instr_valid <= 1'b0;
                    end
                end
                HALT: begin
                    instr_valid <= 1'b0;
                    if (reload) begin
                        load_ptr   <= '0;
                        load_count <= '0;
                        err_oob    <= 1'b0;
                    end
                end
                default: instr_valid <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_ctrl.sv
// tb/tb_imem_ctrl.sv - scoreboard bench for imem_ctrl with instmem
module tb_imem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_valid;
    logic [15:0] load_data;
    logic        load_ready;
    logic        load_done;
    logic        reload;
    logic        fetch_en;
    logic        stall;
    logic        branch_taken;
    logic [11:0] branch_target;
    logic        we_IM;
    logic [15:0] dataIM;
    logic [11:0] addIM;
    logic [15:0] outIM;
    logic [15:0] instr;
    logic        instr_valid;
    logic [11:0] instr_pc;
    logic [12:0] load_count;
    logic        err_oob;

    always #5 clk = ~clk;

    imem_ctrl dut (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
        .load_ready(load_ready), .load_done(load_done), .reload(reload),
        .fetch_en(fetch_en), .stall(stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .we_IM(we_IM), .dataIM(dataIM),
        .addIM(addIM), .outIM(outIM), .instr(instr), .instr_valid(instr_valid),
        .instr_pc(instr_pc), .load_count(load_count), .err_oob(err_oob)
    );

    instmem mem_i (
        .clk(clk), .we_IM(we_IM), .dataIM(dataIM), .addIM(addIM), .outIM(outIM)
    );

    typedef struct packed {
        logic [15:0] word;
        logic [11:0] pc;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] exp_mem [0:15];
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_fetch(input int a);
        exp_t e;
        e.word = exp_mem[a];
        e.pc   = 12'(a);
        sb.push_back(e);
    endtask

    // Monitor: every valid instruction must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (instr_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got instr_pc %0h with empty scoreboard", instr_pc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_instr", 32'(instr), 32'(e.word));
                chk("sb_instr_pc", 32'(instr_pc), 32'(e.pc));
            end
        end
    end

    initial begin
        rst = 1'b1; load_valid = 1'b0; load_data = '0; load_done = 1'b0; reload = 1'b0;
        fetch_en = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
        next_cycle();
        @(negedge clk);
        chk("rst_we_IM", 32'(we_IM), 0);
        chk("rst_load_ready", 32'(load_ready), 0);
        chk("rst_instr_valid", 32'(instr_valid), 0);
        chk("rst_err_oob", 32'(err_oob), 0);
        chk("rst_load_count", 32'(load_count), 0);
        chk("rst_instr_pc", 32'(instr_pc), 0);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_load_ready", 32'(load_ready), 1);
        next_cycle();

        // Full 16-word load, back to back
        for (int i = 0; i < 16; i++) begin
            load_valid = 1'b1;
            load_data  = 16'h1000 + 16'(i);
            exp_mem[i] = 16'h1000 + 16'(i);
            @(negedge clk);
            chk("load16_we_IM", 32'(we_IM), 1);
            chk("load16_addIM", 32'(addIM), 32'(i));
            chk("load16_dataIM", 32'(dataIM), 32'(16'h1000 + 16'(i)));
            next_cycle();
        end
        load_valid = 1'b0;
        @(negedge clk);
        chk("full_load_ready", 32'(load_ready), 0);
        chk("full_load_count", 32'(load_count), 16);
        chk("full_addIM", 32'(addIM), 16);
        next_cycle();

        // Sequential fetch 0..5, stall three cycles at 5, then 6
        for (int k = 0; k < 6; k++) begin
            fetch_en = 1'b1;
            @(negedge clk);
            chk("run1_addIM", 32'(addIM), 32'(k));
            chk("run1_we_IM", 32'(we_IM), 0);
            expect_fetch(k);
            next_cycle();
        end
        for (int s = 0; s < 3; s++) begin
            stall = 1'b1;
            @(negedge clk);
            chk("stall_addIM", 32'(addIM), 5);
            chk("stall_instr_pc", 32'(instr_pc), 5);
            expect_fetch(5);
            next_cycle();
        end
        stall = 1'b0;
        @(negedge clk);
        chk("unstall_addIM", 32'(addIM), 6);
        expect_fetch(6);
        next_cycle();
        fetch_en = 1'b0;
        next_cycle();
        @(negedge clk);
        chk("fetch_dis_valid", 32'(instr_valid), 0);
        reload = 1'b1;
        next_cycle();
        reload = 1'b0;
        @(negedge clk);
        chk("reload_run_ready", 32'(load_ready), 1);
        chk("reload_run_count", 32'(load_count), 0);
        chk("reload_run_addIM", 32'(addIM), 0);
        next_cycle();

        // Short load ended by load_done alongside a fourth word
        for (int i = 0; i < 4; i++) begin
            load_valid = 1'b1;
            load_done  = (i == 3);
            load_data  = 16'h2000 + 16'(i);
            exp_mem[i] = 16'h2000 + 16'(i);
            @(negedge clk);
            chk("load4_we_IM", 32'(we_IM), 1);
            chk("load4_addIM", 32'(addIM), 32'(i));
            next_cycle();
        end
        load_valid = 1'b0;
        load_done  = 1'b0;
        fetch_en   = 1'b1;
        @(negedge clk);
        chk("load4_count", 32'(load_count), 4);
        for (int k = 0; k < 4; k++) begin
            if (k != 0) @(negedge clk);
            chk("run2_addIM", 32'(addIM), 32'(k));
            expect_fetch(k);
            next_cycle();
        end

        // Stall at 3, then branch to 10 while still stalled
        stall = 1'b1;
        @(negedge clk);
        chk("stall3_addIM", 32'(addIM), 3);
        expect_fetch(3);
        next_cycle();
        branch_taken  = 1'b1;
        branch_target = 12'h00A;
        @(negedge clk);
        chk("branch_addIM", 32'(addIM), 10);
        expect_fetch(10);
        next_cycle();
        stall        = 1'b0;
        branch_taken = 1'b0;
        for (int k = 11; k < 16; k++) begin
            @(negedge clk);
            chk("run3_addIM", 32'(addIM), 32'(k));
            expect_fetch(k);
            next_cycle();
        end

        // Fetch past the end of memory
        @(negedge clk);
        chk("oob_addIM", 32'(addIM), 16);
        chk("pre_oob_err", 32'(err_oob), 0);
        next_cycle();
        @(negedge clk);
        chk("halt_err_oob", 32'(err_oob), 1);
        chk("halt_instr_valid", 32'(instr_valid), 0);
        chk("halt_addIM", 32'(addIM), 16);
        chk("halt_we_IM", 32'(we_IM), 0);
        next_cycle();
        @(negedge clk);
        chk("halt_hold_valid", 32'(instr_valid), 0);
        chk("halt_hold_err", 32'(err_oob), 1);
        reload = 1'b1;
        next_cycle();
        reload   = 1'b0;
        fetch_en = 1'b0;
        @(negedge clk);
        chk("reload_halt_err", 32'(err_oob), 0);
        chk("reload_halt_ready", 32'(load_ready), 1);
        chk("reload_halt_count", 32'(load_count), 0);
        chk("reload_halt_addIM", 32'(addIM), 0);
        next_cycle();

        // Reset in the middle of a load
        for (int i = 0; i < 5; i++) begin
            load_valid = 1'b1;
            load_data  = 16'h3000 + 16'(i);
            exp_mem[i] = 16'h3000 + 16'(i);
            next_cycle();
        end
        rst       = 1'b1;
        load_data = 16'h30AA;
        @(negedge clk);
        chk("midrst_we_IM", 32'(we_IM), 0);
        chk("midrst_ready", 32'(load_ready), 0);
        next_cycle();
        @(negedge clk);
        chk("midrst_count", 32'(load_count), 0);
        chk("midrst_we_IM2", 32'(we_IM), 0);
        rst        = 1'b0;
        load_valid = 1'b0;
        next_cycle();
        load_valid = 1'b1;
        load_done  = 1'b1;
        load_data  = 16'h4000;
        exp_mem[0] = 16'h4000;
        @(negedge clk);
        chk("restart_addIM", 32'(addIM), 0);
        chk("restart_we_IM", 32'(we_IM), 1);
        next_cycle();
        load_valid = 1'b0;
        load_done  = 1'b0;
        fetch_en   = 1'b1;
        @(negedge clk);
        chk("restart_count", 32'(load_count), 1);
        chk("restart_run_addIM", 32'(addIM), 0);
        expect_fetch(0);
        next_cycle();
        fetch_en = 1'b0;
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imem_ctrl.md
Name: imem_ctrl

Overview:
Sequencer for the 16x16 instruction memory (instmem). After reset it runs a load phase that streams program words into memory from a valid/ready loader port. It then switches to a run phase that fetches sequentially from a program counter, with stall, branch redirect, and out-of-range detection. It is the only driver of the memory's we_IM/dataIM/addIM inputs and presents fetched instructions to the decode stage.

Parameters:
ADDR_W, 12, instruction memory address width (matches addIM)
DATA_W, 16, instruction word width
DEPTH, 16, implemented memory words; addresses >= DEPTH are out of range
PC_START, 0, PC value after reset and after load completes

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
load_valid  in  1  loader presents a word
load_data  in  DATA_W  word to write
load_ready  out  1  controller accepts a word this cycle
load_done  in  1  loader finished; leave LOAD early
reload  in  1  return to LOAD from RUN or HALT
fetch_en  in  1  fetch permitted
stall  in  1  hold current instruction
branch_taken  in  1  redirect fetch this cycle
branch_target  in  ADDR_W  redirect address
we_IM  out  1  memory write enable
dataIM  out  DATA_W  memory write data
addIM  out  ADDR_W  memory address
outIM  in  DATA_W  memory registered read data
instr  out  DATA_W  fetched instruction (outIM passthrough)
instr_valid  out  1  instr is valid for instr_pc
instr_pc  out  ADDR_W  address of instr
load_count  out  ADDR_W+1  words written in the current load
err_oob  out  1  sticky out-of-range fetch flag

Behaviour:
- All state updates on rising clk edge. rst is sampled synchronously. Memory outputs are combinational from registered state.
- Reset values: state=LOAD, load_ptr=0, load_count=0, pc=PC_START, instr_pc=PC_START, instr_valid=0, err_oob=0. While rst=1, we_IM=0 and load_ready=0.
- States: LOAD, RUN, HALT.
- LOAD state:
  - load_ready = (load_ptr < DEPTH).
  - we_IM = load_valid & load_ready; addIM = load_ptr; dataIM = load_data.
  - On an accepted word, load_ptr and load_count increment.
  - Go to RUN when load_done=1 (a word accepted in the same cycle is still written) or when load_ptr reaches DEPTH. The transition happens on the following edge.
  - On entry to RUN: pc=PC_START, instr_valid=0.
- RUN state:
  - we_IM=0; dataIM=0; load_ready=0.
  - Address mux, in priority order:
    - branch_taken: addIM = branch_target.
    - else stall & instr_valid: addIM = instr_pc (re-read keeps outIM stable).
    - else: addIM = pc.
  - Issue condition: fetch_en & (branch_taken | !stall). On issue, at the edge: instr_pc <= addIM, pc <= addIM+1 (mod 2^ADDR_W), instr_valid <= 1.
  - stall without branch: pc, instr_pc and instr_valid hold.
  - fetch_en=0: no issue, instr_valid <= 0, pc holds.
  - Latency: address presented in cycle N; instr/instr_valid valid in cycle N+1.
  - Branch has priority over stall. Wrong-path squash is the consumer's responsibility.
- Out of range:
  - If an issue would use addIM >= DEPTH, do not issue. Set err_oob=1 and instr_valid=0, and go to HALT.
  - HALT: we_IM=0, addIM=pc, instr_valid=0.
- reload=1 in RUN or HALT: go to LOAD; clear load_ptr, load_count and err_oob. reload is ignored in LOAD.
- rst mid-load or mid-run: immediately returns to reset values. Words already written stay in memory.
- Simultaneous load_done and load_ptr==DEPTH: single transition to RUN.

Decomposition:
- Package imem_pkg holds:
  - state encoding (LOAD=2'd0, RUN=2'd1, HALT=2'd2)
  - ADDR_W, DATA_W and DEPTH defaults
  - the next-address function
- No sub-module. Single FSM plus PC/pointer registers.
- The bench instantiates imem_ctrl together with instmem.

Test Plan:
- Reset, then load 16 words 16'h1000..16'h100F back-to-back -> we_IM high 16 cycles with addIM 0..15; load_ready drops after the 16th; RUN next cycle; instr sequence 16'h1000,16'h1001,... with instr_pc 0,1,...
- Load 3 words, then load_done with a 4th word valid the same cycle -> 4 writes; load_count=4; RUN fetches from PC_START.
- RUN, stall held 3 cycles while instr_pc=5 -> instr and instr_pc=5 stay constant and addIM=5; after release, next instr_pc=6.
- branch_taken with target 12'h00A while stalled at instr_pc=3 -> next cycle instr_pc=10 with mem[10]; then 11, 12.
- Sequential fetch from pc=15 -> issue at 16 refused; err_oob=1, instr_valid=0, state HALT; reload pulse -> LOAD, err_oob=0, load_ready=1.
- rst asserted mid-load after 5 words -> load_count=0, we_IM=0 during rst; the next load restarts at addIM=0.
